// File: rtl/datatape_pkg.sv
// Shared definitions for the video-out scheduler: FSM state encoding,
// payload opcode and FIFO sizing defaults.
package datatape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_PAY_ACC = 3'd3,
        ST_PAY_LO  = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    localparam int          FIFO_DEPTH_DEF  = 2048;
    localparam int          FULL_THRESH_DEF = 2040;
    localparam logic [7:0]  OP_DATA_DEF     = 8'hA5;

endpackage

// File: rtl/sat_counter.sv
// 16-bit event counter that sticks at all-ones; registered output,
// increments on the clock edge after inc is seen high.
module sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 16'd0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/vout_sched.sv
// Parses opcode/LEN framed byte stream and writes payload as nibbles, hi first, 1 and 2 cycles after accept.
// Backpressure: rx_ready drops in PAY_LO and in PAY_ACC while the FIFO fill level reaches FULL_THRESH.
module vout_sched
    import datatape_pkg::*;
#(
    parameter int         FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int         FULL_THRESH = FULL_THRESH_DEF,
    parameter logic [7:0] OP_DATA     = OP_DATA_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic                          rx_last,
    input  logic                          rx_user,
    output logic [3:0]                    fifow_data,
    output logic                          fifow_request,
    input  logic [$clog2(FIFO_DEPTH)-1:0] fifow_used_words,
    output logic                          busy,
    output logic [15:0]                   cnt_frames,
    output logic [15:0]                   cnt_errors
);

    state_t      state;
    state_t      after_lo;
    state_t      end_state;
    logic [15:0] remaining;
    logic [15:0] len_full;
    logic [15:0] rem_dec;
    logic [3:0]  lo_nib;
    logic        room;
    logic        xfer;
    logic        cnt_zero;
    logic        ev_good;
    logic        ev_err;

    assign room     = 32'(fifow_used_words) < FULL_THRESH;
    assign rx_ready = (state == ST_PAY_ACC) ? room : (state != ST_PAY_LO);
    assign busy     = (state != ST_IDLE);
    assign xfer     = rx_valid && rx_ready;

    assign len_full = {remaining[15:8], rx_data};
    assign rem_dec  = remaining - 16'd1;

    // LEN_LO and PAY_ACC share the same end-of-frame rules, keyed on the
    // count of payload bytes still owed after this byte.
    assign cnt_zero = (state == ST_LEN_LO) ? (len_full == 16'd0) : (rem_dec == 16'd0);

    always_comb begin
        end_state = ST_PAY_ACC;
        if (rx_last)       end_state = ST_IDLE;
        else if (cnt_zero) end_state = ST_DISCARD;
    end

    always_comb begin
        ev_good = 1'b0;
        ev_err  = 1'b0;
        if (xfer) begin
            case (state)
                ST_IDLE:   ev_err = rx_last || (rx_data != OP_DATA);
                ST_LEN_HI: ev_err = rx_last;
                ST_LEN_LO, ST_PAY_ACC: begin
                    if (cnt_zero && rx_last) begin
                        ev_good = !rx_user;
                        ev_err  = rx_user;
                    end else begin
                        ev_err  = cnt_zero || rx_last;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            after_lo      <= ST_IDLE;
            remaining     <= 16'd0;
            lo_nib        <= 4'd0;
            fifow_data    <= 4'd0;
            fifow_request <= 1'b0;
        end else begin
            fifow_request <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (rx_last)                 state <= ST_IDLE;
                        else if (rx_data == OP_DATA) state <= ST_LEN_HI;
                        else                         state <= ST_DISCARD;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        remaining[15:8] <= rx_data;
                        state           <= rx_last ? ST_IDLE : ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        remaining[7:0] <= rx_data;
                        state          <= end_state;
                    end
                end
                ST_PAY_ACC: begin
                    if (xfer) begin
                        remaining     <= rem_dec;
                        fifow_data    <= rx_data[7:4];
                        fifow_request <= 1'b1;
                        lo_nib        <= rx_data[3:0];
                        after_lo      <= end_state;
                        state         <= ST_PAY_LO;
                    end
                end
                ST_PAY_LO: begin
                    // Low nibble goes out regardless of what follows.
                    fifow_data    <= lo_nib;
                    fifow_request <= 1'b1;
                    state         <= after_lo;
                end
                ST_DISCARD: begin
                    if (xfer && rx_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sat_counter u_cnt_frames (
        .clk   (clk),
        .rst   (rst),
        .inc   (ev_good),
        .count (cnt_frames)
    );

    sat_counter u_cnt_errors (
        .clk   (clk),
        .rst   (rst),
        .inc   (ev_err),
        .count (cnt_errors)
    );

endmodule
